control_salto: RTL
==================

Name: control_salto

Overview:
- ID-stage branch resolution and PC-redirect controller, directly downstream of the 32-bit register equality comparator.
- Consumes the comparator's `igual` flag plus ID-stage decode fields and owns the PC register.
- Resolves beq/bne/j in ID and flushes IF/ID on redirect.
- Stalls the front end when a branch operand is not yet forwardable.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- ANCHO, 32, datapath/PC width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- igual  in  1  equality flag from the comparator (rs value == rt value, after forwarding).
- id_valid  in  1  ID holds a real instruction (0 = bubble).
- id_beq  in  1  ID instruction is beq.
- id_bne  in  1  ID instruction is bne.
- id_jump  in  1  ID instruction is j.
- id_rs  in  5  ID source register rs.
- id_rt  in  5  ID source register rt.
- id_imm  in  16  branch offset, words.
- id_jidx  in  26  jump index.
- id_pc4  in  32  PC+4 of the ID instruction.
- ex_regwrite  in  1  EX instruction writes the register file.
- ex_memread  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- mem_memread  in  1  MEM instruction is a load.
- mem_rd  in  5  MEM destination register.
- ext_stall  in  1  global freeze from elsewhere in the pipeline.
- pc  out  32  registered fetch PC.
- stall  out  1  hold IF/ID and PC, insert bubble into ID/EX.
- if_id_flush  out  1  clear IF/ID at the next edge.
- salto_tomado  out  1  redirect taken this cycle (branch or jump).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - pc=PC_RESET; FSM=RUN.
  - stall, if_id_flush and salto_tomado evaluate to 0 while rst_n=0.
  - Reset overrides everything, including a reset mid-ESPERA.
- Branch qualifier: br = id_valid & (id_beq | id_bne).
- match(r) = (r != 0) & (r == id_rs | r == id_rt).
- Required stall cycles:
  - need2 = br & ex_memread & match(ex_rd).
  - need1 = br & !need2 & ((ex_regwrite & match(ex_rd)) | (mem_memread & match(mem_rd))).
  - hazard = need1 | need2.
- FSM states RUN and ESPERA:
  - RUN: stall = hazard. If need2 then next state is ESPERA, else stay in RUN.
  - ESPERA: stall = 1, no branch decision is made; next state is RUN. Hazard is re-evaluated in RUN.
- Decision (only in RUN with !hazard and !ext_stall):
  - tomado_br = br & ((id_beq & igual) | (id_bne & !igual)).
  - tomado_j = id_valid & id_jump; jumps never stall.
  - salto_tomado = tomado_br | tomado_j.
  - if_id_flush = salto_tomado.
- Targets (all arithmetic mod 2^32, wrap silently):
  - Branch target = id_pc4 + ({{14{id_imm[15]}}, id_imm, 2'b00}).
  - Jump target = {id_pc4[31:28], id_jidx, 2'b00}.
- PC update priority:
  1. reset
  2. ext_stall | stall → hold
  3. tomado_j → jump target
  4. tomado_br → branch target
  5. pc + 4
- ext_stall:
  - freezes the FSM state and pc;
  - forces salto_tomado = 0 and if_id_flush = 0;
  - stall still reports the hazard.
- If both id_beq and id_bne are asserted (illegal decode), beq takes priority.
- Latency: a redirect is visible on pc one cycle after the decision cycle. Exactly one fetched instruction is flushed; there is no delay slot.

Optional Feature:
- Macro: CONTADORES_SALTO_EN.
- When defined, the block adds three 32-bit output ports, each zeroed on reset and wrapping at 2^32:
  - num_saltos: increments on each decided branch or jump (RUN, !hazard, !ext_stall, br | tomado_j).
  - num_tomados: increments on each cycle with salto_tomado = 1.
  - ciclos_stall: increments on every cycle with stall = 1 and !ext_stall.
- When undefined, these ports and their registers do not exist.

Decomposition:
- Shared package/header pipeline_defs holds:
  - FSM state encodings (RUN=1'b0, ESPERA=1'b1);
  - PC increment constant 4;
  - register-zero constant 5'd0.
- One combinational sub-module, detector_riesgo_salto, computes need1, need2 and hazard from the ID/EX/MEM fields.
- Target calculation, the FSM and the PC register stay in control_salto.

Test Plan:
- Reset → pc=0. Release with id_valid=0 → pc steps 0, 4, 8, 12; stall=0 and if_id_flush=0 throughout.
- beq taken:
  - Stimulus: id_pc4=0x100, id_imm=0xFFFE, igual=1.
  - Response: salto_tomado=1 and if_id_flush=1 that cycle; next pc=0xF8.
  - Same case with bne → pc = previous pc + 4, no flush.
- Load-use on branch:
  - Stimulus: ex_memread=1, ex_rd=8, id_rs=8, beq held in ID.
  - Response: stall=1 for exactly 2 cycles (RUN, then ESPERA); pc held; the decision is made on the 3rd cycle.
- ALU hazard:
  - Stimulus: ex_regwrite=1, ex_rd=9, id_rt=9.
  - Response: 1 stall cycle.
  - With ex_rd=0 instead → no stall.
- Jump:
  - Stimulus: id_pc4=0xA000_0004, id_jidx=0x000_0010, with ex_memread=1 and ex_rd matching rs.
  - Response: no stall; next pc=0xA000_0040; if_id_flush=1.
- ext_stall=1 during a taken beq → pc held, no flush. Assert rst_n=0 in ESPERA → next cycle pc=PC_RESET, FSM=RUN, stall=0.

Source files
------------

// File: rtl/pipeline_defs.sv
// pipeline_defs: shared FSM encodings and constants for the ID-stage branch controller.
package pipeline_defs;
  typedef enum logic {RUN = 1'b0, ESPERA = 1'b1} state_t;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/control_salto_if.sv
// control_salto_if: ID/EX/MEM fields into the branch controller and its PC/flush/stall outputs.
// CONTADORES_SALTO_EN adds the three statistics counters.
interface control_salto_if;
  logic igual, id_valid, id_beq, id_bne, id_jump;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic [15:0] id_imm;
  logic [25:0] id_jidx;
  logic [31:0] id_pc4, pc;
  logic ex_regwrite, ex_memread, mem_memread, ext_stall;
  logic stall, if_id_flush, salto_tomado;
`ifdef CONTADORES_SALTO_EN
  logic [31:0] num_saltos, num_tomados, ciclos_stall;
`endif
  modport master (
    output igual, id_valid, id_beq, id_bne, id_jump, id_rs, id_rt, id_imm, id_jidx, id_pc4,
    output ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd, ext_stall,
    input pc, stall, if_id_flush, salto_tomado
`ifdef CONTADORES_SALTO_EN
    , input num_saltos, num_tomados, ciclos_stall
`endif
  );
  modport slave (
    input igual, id_valid, id_beq, id_bne, id_jump, id_rs, id_rt, id_imm, id_jidx, id_pc4,
    input ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd, ext_stall,
    output pc, stall, if_id_flush, salto_tomado
`ifdef CONTADORES_SALTO_EN
    , output num_saltos, num_tomados, ciclos_stall
`endif
  );
endinterface

// File: rtl/detector_riesgo_salto.sv
// detector_riesgo_salto: stall cycles a branch in ID needs before its operands are forwardable.
module detector_riesgo_salto
  import pipeline_defs::*;
(
  input  logic       br,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       mem_memread,
  input  logic [4:0] mem_rd,
  output logic       need1,
  output logic       need2,
  output logic       hazard
);
  function automatic logic match(input logic [4:0] r, input logic [4:0] a, input logic [4:0] b);
    return (r != REG_ZERO) && (r == a || r == b);
  endfunction
  assign need2 = br & ex_memread & match(ex_rd, id_rs, id_rt);
  assign need1 = br & !need2 & ((ex_regwrite & match(ex_rd, id_rs, id_rt)) |
                                (mem_memread & match(mem_rd, id_rs, id_rt)));
  assign hazard = need1 | need2;
endmodule

// File: rtl/control_salto.sv
// control_salto: resolves beq/bne/j in ID, owns the fetch PC, flushes IF/ID on redirect.
// Defining CONTADORES_SALTO_EN adds num_saltos/num_tomados/ciclos_stall counters.
module control_salto
  import pipeline_defs::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int ANCHO = 32
) (
  input logic clk,
  input logic rst_n,
  control_salto_if.slave bus
);
  state_t st;
  logic [ANCHO-1:0] pc_q, br_tgt, j_tgt;
  logic br, need1, need2, hazard, stall, decide, tomado_br, tomado_j;
  detector_riesgo_salto det (
    .br(br), .id_rs(bus.id_rs), .id_rt(bus.id_rt),
    .ex_regwrite(bus.ex_regwrite), .ex_memread(bus.ex_memread), .ex_rd(bus.ex_rd),
    .mem_memread(bus.mem_memread), .mem_rd(bus.mem_rd),
    .need1(need1), .need2(need2), .hazard(hazard)
  );
  assign br = bus.id_valid & (bus.id_beq | bus.id_bne);
  assign stall = rst_n & (st == ESPERA | need1 | need2);
  assign decide = rst_n & (st == RUN) & !hazard & !bus.ext_stall;
  // beq wins over an illegal beq+bne decode
  assign tomado_br = decide & br & (bus.id_beq ? bus.igual : !bus.igual);
  assign tomado_j = decide & bus.id_valid & bus.id_jump;
  assign br_tgt = bus.id_pc4 + {{14{bus.id_imm[15]}}, bus.id_imm, 2'b00};
  assign j_tgt = {bus.id_pc4[31:28], bus.id_jidx, 2'b00};
  assign bus.pc = pc_q;
  assign bus.stall = stall;
  assign bus.salto_tomado = tomado_br | tomado_j;
  assign bus.if_id_flush = tomado_br | tomado_j;
  always_ff @(posedge clk)
    if (!rst_n) begin
      st <= RUN;
      pc_q <= PC_RESET;
    end else if (!bus.ext_stall) begin
      st <= (st == RUN && need2) ? ESPERA : RUN;
      pc_q <= stall ? pc_q : tomado_j ? j_tgt : tomado_br ? br_tgt : pc_q + PC_INC;
    end
`ifdef CONTADORES_SALTO_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      bus.num_saltos <= '0;
      bus.num_tomados <= '0;
      bus.ciclos_stall <= '0;
    end else begin
      if (decide & (br | tomado_j)) bus.num_saltos <= bus.num_saltos + 32'd1;
      if (tomado_br | tomado_j) bus.num_tomados <= bus.num_tomados + 32'd1;
      if (stall & !bus.ext_stall) bus.ciclos_stall <= bus.ciclos_stall + 32'd1;
    end
`endif
endmodule
